// File: rtl/spi_arbiter.sv
// spi_arbiter -- shares one SPI RAM transaction engine between two requesters.
//
// Port 0 is CPU instruction fetch and port 1 is CPU data load/store. The
// granted command is latched into the spi_* registers. It then stays stable
// until the engine transaction is acknowledged back to its owner.
//
// Build option:
//   SPI_ARB_RR_EN  defined   -> round-robin when both ports request.
//                  undefined -> fixed priority, port 0 wins.
//
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   pN_req/write/addr/wdata     requester N command (held until pN_ack)
//   pN_ack                      one-cycle completion pulse for port N
//   pN_rdata                    last read data returned to port N
//   spi_start                   engine start strobe
//   spi_write/address/databus   command presented to the engine
//   spi_done, spi_data          engine idle/done flag and read data
//   busy                        arbiter is not idle
//   owner                       port currently or most recently granted
module spi_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_write,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_write,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              spi_start,
   output logic              spi_write,
   output logic [ADDR_W-1:0] spi_address,
   output logic [DATA_W-1:0] spi_databus,
   input  logic              spi_done,
   input  logic [DATA_W-1:0] spi_data,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      RESPOND
   } state_t;

   state_t state, state_next;

   logic grant_valid;
   logic grant_port;

   // Arbitration only matters in IDLE. A lone requester always wins.
   always_comb begin
      grant_valid = p0_req | p1_req;
`ifdef SPI_ARB_RR_EN
      if (p0_req && p1_req)
         grant_port = ~owner;
      else
         grant_port = ~p0_req;
`else
      grant_port = ~p0_req;
`endif
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (grant_valid) state_next = ISSUE;
         // Start is only offered to an idle engine. Otherwise wait here.
         ISSUE:     if (spi_done) state_next = WAIT_BUSY;
         WAIT_BUSY: if (!spi_done) state_next = WAIT_DONE;
         WAIT_DONE: if (spi_done) state_next = RESPOND;
         RESPOND:   state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         owner       <= 1'b1;
         spi_write   <= 1'b0;
         spi_address <= '0;
         spi_databus <= '0;
         p0_rdata    <= '0;
         p1_rdata    <= '0;
      end else begin
         state <= state_next;
         // The command registers load only on grant. The engine samples them
         // continuously, so they must not move until IDLE comes round again.
         if (state == IDLE && grant_valid) begin
            owner <= grant_port;
            if (grant_port) begin
               spi_write   <= p1_write;
               spi_address <= p1_addr;
               spi_databus <= p1_wdata;
            end else begin
               spi_write   <= p0_write;
               spi_address <= p0_addr;
               spi_databus <= p0_wdata;
            end
         end
         // Capture read data on the edge where the engine reports done.
         // Write transactions leave rdata untouched.
         if (state == WAIT_DONE && spi_done && !spi_write) begin
            if (owner)
               p1_rdata <= spi_data;
            else
               p0_rdata <= spi_data;
         end
      end
   end

   assign spi_start = (state == ISSUE) && spi_done;
   assign p0_ack    = (state == RESPOND) && !owner;
   assign p1_ack    = (state == RESPOND) && owner;
   assign busy      = (state != IDLE);

endmodule
